pool_window2x2: RTL

Streaming 2x2 window former that sits directly upstream of the 2x2 max-pool comparator stage in the renkon pooling path. It accepts one feature-map pixel per valid cycle in raster order, buffers one row, and emits each non-overlapping stride-2 window as four parallel pixels. It also produces the pool stage's output-enable, delayed to match that stage's input register.

---
 rtl/pool_window2x2_pkg.sv | 15 +
 rtl/pool_linebuf.sv | 48 ++++
 rtl/pool_window2x2.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pool_window2x2_pkg.sv
// Shared renkon pooling definitions: default pixel width, maximum map width
// and the window-former FSM state encoding.
// No logic; imported by pool_window2x2 and pool_linebuf.
package pool_window2x2_pkg;

  localparam int DWIDTH  = 16;
  localparam int MAXFMAP = 32;

  typedef enum logic [1:0] {
    POOLWIN_IDLE  = 2'd0,
    POOLWIN_RUN   = 2'd1,
    POOLWIN_FLUSH = 2'd2
  } poolwin_state_e;

endpackage

// File: rtl/pool_linebuf.sv
// One-row line buffer for the 2x2 window former.
// Ports: wr_* writes a pixel of an even row; cap_en/cap_addr captures the
// pair buf[a], buf[a+1] (a even) into shadow registers read as rd_data0/1.
// Latency: shadow pair valid the cycle after cap_en; no backpressure.
module pool_linebuf #(
  parameter int DWIDTH  = pool_window2x2_pkg::DWIDTH,
  parameter int MAXFMAP = pool_window2x2_pkg::MAXFMAP,
  parameter int AW      = (MAXFMAP > 1) ? $clog2(MAXFMAP) : 1
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [DWIDTH-1:0] wr_data,
  input  logic                     cap_en,
  input  logic [AW-1:0]            cap_addr,
  output logic signed [DWIDTH-1:0] rd_data0,
  output logic signed [DWIDTH-1:0] rd_data1
);

  logic signed [DWIDTH-1:0] mem [MAXFMAP];
  logic signed [DWIDTH-1:0] sh0_q, sh1_q;
  logic [AW-1:0]            addr1;

  assign addr1 = cap_addr + AW'(1);

  // Storage carries no reset: contents are always written before being read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The pair is fetched on the even column of an odd row, one pixel before
  // the window closes, so the window output mux sees registers, not the RAM.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      sh0_q <= '0;
      sh1_q <= '0;
    end else if (cap_en) begin
      sh0_q <= mem[cap_addr];
      // Only reachable past the end for an odd MAXFMAP; that column never closes a window.
      sh1_q <= (int'(addr1) < MAXFMAP) ? mem[addr1] : mem[cap_addr];
    end
  end

  assign rd_data0 = sh0_q;
  assign rd_data1 = sh1_q;

endmodule

// File: rtl/pool_window2x2.sv
// Streaming stride-2 2x2 window former feeding the max-pool comparator.
// Ports: init/fea_size start a frame; pixel_valid/pixel_in raster stream in;
// pixel_feat[0..3] (TL,TR,BL,BR) + win_valid out, pool_en = win_valid delayed,
// busy, frame_done.
// Latency: window registered 1 cycle after the bottom-right pixel; no backpressure.
module pool_window2x2
  import pool_window2x2_pkg::*;
#(
  parameter int DWIDTH  = pool_window2x2_pkg::DWIDTH,
  parameter int MAXFMAP = pool_window2x2_pkg::MAXFMAP,
  parameter int FSIZEW  = $clog2(MAXFMAP + 1)
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     init,
  input  logic [FSIZEW-1:0]        fea_size,
  input  logic                     pixel_valid,
  input  logic signed [DWIDTH-1:0] pixel_in,
  output logic signed [DWIDTH-1:0] pixel_feat [4],
  output logic                     win_valid,
  output logic                     pool_en,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int AW = (MAXFMAP > 1) ? $clog2(MAXFMAP) : 1;

  poolwin_state_e           state_q;
  logic [FSIZEW-1:0]        size_q, col_q, row_q;
  logic signed [DWIDTH-1:0] prev_q;
  logic signed [DWIDTH-1:0] feat_q [4];
  logic                     win_valid_q, pool_en_q, busy_q, frame_done_q;

  logic                     accept, win_fire, col_last, row_last;
  logic [FSIZEW-1:0]        last_idx;
  logic signed [DWIDTH-1:0] lb_rd0, lb_rd1;

  // init takes priority over a pixel offered in the same cycle.
  assign accept   = (state_q == POOLWIN_RUN) && pixel_valid && !init;
  assign last_idx = size_q - FSIZEW'(1);
  assign col_last = (col_q == last_idx);
  assign row_last = (row_q == last_idx);
  // Bottom-right corner of a window: odd row, odd column.
  assign win_fire = accept && row_q[0] && col_q[0];

  pool_linebuf #(
    .DWIDTH  (DWIDTH),
    .MAXFMAP (MAXFMAP),
    .AW      (AW)
  ) u_linebuf (
    .clk      (clk),
    .xrst     (xrst),
    .wr_en    (accept && !row_q[0]),
    .wr_addr  (col_q[AW-1:0]),
    .wr_data  (pixel_in),
    .cap_en   (accept && row_q[0] && !col_q[0]),
    .cap_addr (col_q[AW-1:0]),
    .rd_data0 (lb_rd0),
    .rd_data1 (lb_rd1)
  );

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q      <= POOLWIN_IDLE;
      size_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      prev_q       <= '0;
      for (int i = 0; i < 4; i++) feat_q[i] <= '0;
      win_valid_q  <= 1'b0;
      pool_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      // Aligns with the pool stage's input register.
      pool_en_q    <= win_valid_q;
      if (init) begin
        state_q <= POOLWIN_RUN;
        busy_q  <= 1'b1;
        size_q  <= fea_size;
        col_q   <= '0;
        row_q   <= '0;
      end else begin
        case (state_q)
          POOLWIN_RUN: begin
            if (accept) begin
              prev_q <= pixel_in;
              if (win_fire) begin
                feat_q[0]   <= lb_rd0;
                feat_q[1]   <= lb_rd1;
                feat_q[2]   <= prev_q;
                feat_q[3]   <= pixel_in;
                win_valid_q <= 1'b1;
              end
              if (col_last) begin
                col_q <= '0;
                if (row_last) begin
                  row_q        <= '0;
                  state_q      <= POOLWIN_FLUSH;
                  frame_done_q <= 1'b1;
                end else begin
                  row_q <= row_q + FSIZEW'(1);
                end
              end else begin
                col_q <= col_q + FSIZEW'(1);
              end
            end
          end
          POOLWIN_FLUSH: begin
            state_q <= POOLWIN_IDLE;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign pixel_feat = feat_q;
  assign win_valid  = win_valid_q;
  assign pool_en    = pool_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
